// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, colour type and helpers
//
// Contents:
//   VGA_* timing defaults for 640x480@60 Hz with a 25 MHz pixel clock
//   VGA_PIPE_DELAY  default sync/blank delay, which matches the PPU colour latency
//   rgb_t           6-bit colour {R1,R0,G1,G0,B1,B0}
//   VGA_FG_COLOUR / VGA_BG_COLOUR  colours shown for colour_in = 1 / 0
//   vga_total()     total period of one axis (visible + front + sync + back)

package vga_pkg;

    localparam int CNT_W          = 10;

    localparam int VGA_H_VISIBLE  = 640;
    localparam int VGA_H_FRONT    = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BACK     = 48;

    localparam int VGA_V_VISIBLE  = 480;
    localparam int VGA_V_FRONT    = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BACK     = 33;

    localparam int VGA_PIPE_DELAY = 3;

    typedef logic [5:0] rgb_t;

    localparam rgb_t VGA_FG_COLOUR = 6'b111111;
    localparam rgb_t VGA_BG_COLOUR = 6'b000000;

    function automatic int vga_total(input int visible, input int front,
                                     input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int VGA_H_TOTAL = vga_total(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
    localparam int VGA_V_TOTAL = vga_total(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - fixed-depth shift register for sync/blank alignment
//
// Parameters:
//   WIDTH  bits carried per stage
//   DEPTH  number of register stages (>= 1)
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-low; every stage loads reset_value
//   reset_value  value held by all stages while in reset (the idle pattern)
//   din          raw bits entering the line
//   dout         last stage (din delayed by DEPTH cycles)
//   dout_next    value dout will take on the next edge; lets a downstream
//                register line up with dout after its own one-cycle latency

module sync_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] reset_value,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_next
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= reset_value;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_single
            assign dout_next = din;
        end else begin : g_multi
            assign dout_next = stage[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_controller.sv
// rtl/vga_timing_controller.sv - 640x480@60 Hz VGA timing generator with delayed sync
//
// Optional feature macro: VGA_TEST_PATTERN_EN (adds test_mode and colour bars)
//
// Ports:
//   clk          pixel clock, 25 MHz
//   reset        synchronous, active-low
//   colour_in    pixel from the PPU (0 black, 1 white)
//   test_mode    only with VGA_TEST_PATTERN_EN: 1 replaces colour_in by bars
//   counter_H    horizontal position 0..H_TOTAL-1 (undelayed, feeds the PPU)
//   counter_V    vertical position 0..V_TOTAL-1 (undelayed, feeds the PPU)
//   hsync        horizontal sync, active-low, delayed by PIPE_DELAY
//   vsync        vertical sync, active-low, delayed by PIPE_DELAY
//   display_on   visible-area flag, delayed by PIPE_DELAY
//   rgb          {R1,R0,G1,G0,B1,B0}, zero outside the visible area
//   frame_start  one-cycle pulse while the counters sit at (0,0)
//   frame_count  completed frames, wraps 255 -> 0

module vga_timing_controller
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE  = VGA_H_VISIBLE,
    parameter int   H_FRONT    = VGA_H_FRONT,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_BACK     = VGA_H_BACK,
    parameter int   V_VISIBLE  = VGA_V_VISIBLE,
    parameter int   V_FRONT    = VGA_V_FRONT,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_BACK     = VGA_V_BACK,
    parameter int   PIPE_DELAY = VGA_PIPE_DELAY,
    parameter rgb_t FG_COLOUR  = VGA_FG_COLOUR,
    parameter rgb_t BG_COLOUR  = VGA_BG_COLOUR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             colour_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    output logic [CNT_W-1:0] counter_H,
    output logic [CNT_W-1:0] counter_V,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic [5:0]       rgb,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    localparam int H_TOTAL = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS     = 10'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS     = 10'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Delay-line bit layout: [2]=hsync, [1]=vsync, [0]=active; the test
    // pattern build appends the three bar bits (counter_H[9:7]) above them.
`ifdef VGA_TEST_PATTERN_EN
    localparam int               DL_W    = 6;
    localparam logic [DL_W-1:0]  DL_IDLE = 6'b000_110;
`else
    localparam int               DL_W    = 3;
    localparam logic [DL_W-1:0]  DL_IDLE = 3'b110;
`endif

    logic            h_wrap;
    logic            v_wrap;
    logic            hs_raw;
    logic            vs_raw;
    logic            act_raw;
    logic [DL_W-1:0] dl_in;
    logic [DL_W-1:0] dl_out;
    logic [DL_W-1:0] dl_next;
    rgb_t            rgb_next;
    logic            unused_tap;

    // ------------------------------------------------------------------
    // Free-running pixel counters; they never stop in blanking.
    // ------------------------------------------------------------------
    assign h_wrap = (counter_H == H_LAST);
    assign v_wrap = (counter_V == V_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_H   <= '0;
            counter_V   <= '0;
            frame_count <= '0;
        end else begin
            if (h_wrap) begin
                counter_H <= '0;
                if (v_wrap) begin
                    counter_V   <= '0;
                    frame_count <= frame_count + 8'd1;
                end else begin
                    counter_V <= counter_V + 10'd1;
                end
            end else begin
                counter_H <= counter_H + 10'd1;
            end
        end
    end

    // Gated by reset so the pulse appears only once counting is enabled.
    assign frame_start = (counter_H == '0) && (counter_V == '0) && reset;

    // ------------------------------------------------------------------
    // Raw sync/active decode from the registered counters.
    // ------------------------------------------------------------------
    assign hs_raw  = !((counter_H >= HS_START) && (counter_H < HS_END));
    assign vs_raw  = !((counter_V >= VS_START) && (counter_V < VS_END));
    assign act_raw = (counter_H < H_VIS) && (counter_V < V_VIS);

`ifdef VGA_TEST_PATTERN_EN
    assign dl_in = {counter_H[9:7], hs_raw, vs_raw, act_raw};
`else
    assign dl_in = {hs_raw, vs_raw, act_raw};
`endif

    sync_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay_line (
        .clk         (clk),
        .reset       (reset),
        .reset_value (DL_IDLE),
        .din         (dl_in),
        .dout        (dl_out),
        .dout_next   (dl_next)
    );

    assign hsync      = dl_out[2];
    assign vsync      = dl_out[1];
    assign display_on = dl_out[0];

    // Only the active/bar bits of the look-ahead tap feed the rgb register.
`ifdef VGA_TEST_PATTERN_EN
    assign unused_tap = &{1'b0, dl_next[2:1], dl_out[5:3]};
`else
    assign unused_tap = &{1'b0, dl_next[2:1]};
`endif

    // ------------------------------------------------------------------
    // Colour register. It is gated with the value display_on takes on the
    // same edge, so rgb and display_on switch together.
    // ------------------------------------------------------------------
    always_comb begin
        rgb_next = '0;
        if (dl_next[0]) begin
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode) begin
                rgb_next = {{2{dl_next[5]}}, {2{dl_next[4]}}, {2{dl_next[3]}}};
            end else begin
                rgb_next = colour_in ? FG_COLOUR : BG_COLOUR;
            end
`else
            rgb_next = colour_in ? FG_COLOUR : BG_COLOUR;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb <= '0;
        end else begin
            rgb <= rgb_next;
        end
    end

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Generates 640x480@60 Hz VGA timing for the 25 MHz pixel clock. It drives the horizontal and vertical pixel counters consumed by the picture processing unit. It accepts the PPU's 1-bit colour back and emits HSYNC, VSYNC and 6-bit RGB to the VGA pins. Sync and blanking are delayed by a fixed pipeline depth so they line up with the PPU's colour latency.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- PIPE_DELAY, 3, cycles of sync/blank delay; legal range 1..7
- FG_COLOUR, 6'b111111, RGB when colour_in=1
- BG_COLOUR, 6'b000000, RGB when colour_in=0

Ports:
- clk  in  1  pixel clock, 25 MHz
- reset  in  1  synchronous, active-low
- colour_in  in  1  pixel from PPU (0 black, 1 white)
- counter_H  out  10  horizontal position 0..H_TOTAL-1
- counter_V  out  10  vertical position 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active-low, delayed
- vsync  out  1  vertical sync, active-low, delayed
- display_on  out  1  visible-area flag, delayed
- rgb  out  6  {R1,R0,G1,G0,B1,B0}
- frame_start  out  1  one-cycle pulse at counter (0,0)
- frame_count  out  8  completed-frame count
- test_mode  in  1  only present with VGA_TEST_PATTERN_EN

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK = 800. V_TOTAL = 525.
- counter_H increments every cycle. It goes 0 at H_TOTAL-1.
- counter_V increments only on the cycle counter_H wraps. It goes 0 at V_TOTAL-1 under the same condition.
- Counters run through blanking with no idle states.
- Raw stage (from registered counters):
  - hs_raw = 0 iff H_VISIBLE+H_FRONT <= counter_H < H_VISIBLE+H_FRONT+H_SYNC
  - vs_raw is defined the same way on counter_V
  - act_raw = counter_H < H_VISIBLE && counter_V < V_VISIBLE
- Delay line: {hs_raw, vs_raw, act_raw} passes through PIPE_DELAY registers.
  - hsync, vsync and display_on are the last stage.
- rgb register:
  - if the delayed active tap is 0: 0
  - else if colour_in=1: FG_COLOUR
  - else: BG_COLOUR
- frame_start = (counter_H==0 && counter_V==0 && reset==1).
- frame_count increments on the (H_TOTAL-1, V_TOTAL-1) -> (0,0) transition and wraps 255 -> 0.
- All arithmetic is unsigned 10-bit. Counters never exceed TOTAL-1.

## Timing
- Reset values:
  - counter_H=0, counter_V=0
  - hsync=1, vsync=1, display_on=0
  - rgb=0, frame_start=0, frame_count=0
  - every delay stage holds the inactive value (1,1,0)
- Reset mid-frame: all of the above take effect on the next edge. Counting resumes from (0,0) on the first edge with reset=1. No partial-frame count is kept.
- hsync, vsync and display_on at cycle t reflect the counters at t-PIPE_DELAY.
- rgb at cycle t uses colour_in sampled at edge t. It is gated by the same delayed active flag as display_on at t.
- Line period: 800 cycles. Frame period: 420000 cycles. hsync low for 96 cycles per line. vsync low for 2 whole lines (1600 cycles).
- frame_start rises exactly once per frame. It is coincident with counter (0,0), not with the delayed outputs.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - the test_mode port exists
  - while test_mode=1, colour_in is ignored
  - {R,G,B} bits come from counter_H[9:7], delayed through the same PIPE_DELAY line
  - each bit is duplicated into both RGB bits: bars of 128 pixels
- VGA_TEST_PATTERN_EN undefined: the test_mode port is absent and rgb depends only on colour_in.

## Structure
- Package vga_pkg holds:
  - default timing constants and the H_TOTAL/V_TOTAL derivation
  - the 6-bit rgb typedef
  - FG/BG colour constants
- Sub-module sync_delay_line: a parameterised-width, PIPE_DELAY-deep shift register with a synchronous reset value input. It carries the sync/active bits, plus bar bits when the test pattern is compiled in.

## Test plan
- Release reset and run 2 frames -> counter_H sequence 0..799. counter_V advances at H wrap and reaches 524 then 0. frame_count=2 after 840000 cycles.
- Measure hsync -> low for exactly 96 cycles, first low at counter_H=656+PIPE_DELAY. vsync low for 1600 cycles starting at counter_V=490 (delayed by PIPE_DELAY).
- Drive colour_in=1 constantly -> rgb=6'b111111 exactly while display_on=1. rgb=0 during all blanking, including the first PIPE_DELAY cycles of each line.
- Drive reset=0 at counter (300,200) for 1 cycle -> next edge gives counters (0,0), hsync=vsync=1, rgb=0, frame_count=0. frame_start asserts only after reset returns high.
- Check frame_count at 255 completed frames -> the next wrap reads 0, with frame_start pulsing once.
- VGA_TEST_PATTERN_EN, test_mode=1, line 0 -> rgb 000000 (cols 0-127), 000011 (128-255), 001100 (256-383), 001111 (384-511), 110000 (512-639), then 0 in blanking.
